// File: rtl/mips_pkg.sv
// Shared widths, constants and fetch state encoding for the MIPS front end.
package mips_pkg;
   localparam int                WORD_W           = 32;
   localparam logic [WORD_W-1:0] PC_INC           = 32'd4;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc4} pairs between the fetch FSM and decode.
module fetch_buffer
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [2*WORD_W-1:0]   push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [1:0]            count,
   output logic [2*WORD_W-1:0]   head
);
   logic [2*WORD_W-1:0] mem_q [2];
   logic [2*WORD_W-1:0] mem_d [2];
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;
   logic                wr_ptr;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_ptr   = rd_ptr_q ^ count_q[0];
      if (flush) begin
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) mem_d[wr_ptr] = push_data;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem handshake and redirect handling.
//   state | meaning
//   FETCH | no request outstanding
//   WAIT  | request outstanding, response will be pushed
//   DRAIN | request outstanding, response will be dropped
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_instr,
   output logic [WORD_W-1:0] out_pc4
);
   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_state_t        state_q, state_d;
   logic [WORD_W-1:0]   pc_q, pc_d;
   logic [WORD_W-1:0]   addr_q, addr_d;
   logic [1:0]          count;
   logic [2*WORD_W-1:0] head;
   logic                issue, push, pop;

   assign issue = (state_q == FETCH) && (count < FULL) && !redirect_valid && !reset;
   assign push  = (state_q == WAIT) && imem_rvalid && !redirect_valid;
   assign pop   = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      if (redirect_valid) pc_d = {redirect_target[WORD_W-1:2], 2'b00};
      unique case (state_q)
         FETCH: begin
            if (issue) begin
               addr_d  = pc_q;
               pc_d    = pc_q + PC_INC;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid)         state_d = FETCH;
            else if (redirect_valid) state_d = DRAIN;
         end
         // A response coinciding with a further redirect still retires the request.
         DRAIN: begin
            if (imem_rvalid) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   fetch_buffer u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({imem_rdata, addr_q + PC_INC}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

   assign imem_req  = issue;
   assign imem_addr = pc_q;
   assign out_valid = (count != 2'd0);
   assign out_instr = head[2*WORD_W-1:WORD_W];
   assign out_pc4   = head[WORD_W-1:0];
endmodule
